// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor: the NOP encoding, the opcode map
// and the instruction memory controller states.
package proc_pkg;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  localparam logic [2:0] ADD  = 3'b000;
  localparam logic [2:0] SUB  = 3'b001;
  localparam logic [2:0] HALT = 3'b011;
  localparam logic [2:0] OUT  = 3'b100;
  localparam logic [2:0] LDI  = 3'b101;
  localparam logic [2:0] BNE  = 3'b110;
  localparam logic [2:0] JMP  = 3'b111;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_storage.sv
// DEPTH x DATA_W instruction array with one write port and one synchronous read port.
module imem_storage #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_ram.sv
// Writable instruction memory: self-clears to NOP after reset, serves registered
// fetches with a valid strobe, and accepts program images over a valid/ready load port.
module instruction_ram
  import proc_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 16,
  parameter int                 DEPTH    = 256,
  parameter logic [DATA_W-1:0]  NOP_WORD = proc_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              busy,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_count,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_error,
  output state_t            state_dbg
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [AW-1:0]    LAST    = AW'(DEPTH - 1);

  // Load handshake: a beat transfers on a cycle where load_valid && load_ready.
  // load_ready is high for the whole LOAD state; gaps in load_valid just stall.

  state_t              state_q, state_d;
  logic [AW-1:0]       clr_ptr_q;
  logic [ADDR_W:0]     ptr_q, rem_q;
  logic                nop_sel_q, valid_q, done_q, err_q;

  logic                fetch_go, start_go, beat, ptr_in_range, fetch_in_range;
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [DATA_W-1:0]   mem_wdata, mem_rdata;

  assign fetch_go       = (state_q == IDLE) && fetch_req && !load_start;
  assign start_go       = (state_q == IDLE) && load_start;
  assign beat           = (state_q == LOAD) && load_valid;
  assign ptr_in_range   = ptr_q < DEPTH_W;
  assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_W;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR: if (clr_ptr_q == LAST) state_d = IDLE;
      IDLE:  if (load_start && (load_count != '0)) state_d = LOAD;
      LOAD:  if (beat && (rem_q == (ADDR_W+1)'(1))) state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    busy       = 1'b1;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clr_ptr_q;
    mem_wdata  = NOP_WORD;
    unique case (state_q)
      CLEAR: mem_we = 1'b1;
      IDLE:  busy = 1'b0;
      LOAD: begin
        load_ready = 1'b1;
        mem_we     = beat && ptr_in_range;
        mem_waddr  = ptr_q[AW-1:0];
        mem_wdata  = load_data;
      end
      default: ;
    endcase
  end

  // nop_sel_q resets high so instruction reads as NOP before the first fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_ptr_q <= '0;
      ptr_q     <= '0;
      rem_q     <= '0;
      nop_sel_q <= 1'b1;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == CLEAR) clr_ptr_q <= clr_ptr_q + AW'(1);
      if (start_go) begin
        ptr_q <= {1'b0, load_base};
        rem_q <= load_count;
      end else if (beat) begin
        ptr_q <= ptr_q + (ADDR_W+1)'(1);
        rem_q <= rem_q - (ADDR_W+1)'(1);
      end
      valid_q <= fetch_go;
      if (fetch_go) nop_sel_q <= !fetch_in_range;
      done_q  <= (start_go && (load_count == '0)) || (beat && (rem_q == (ADDR_W+1)'(1)));
      if (start_go)                  err_q <= 1'b0;
      else if (beat && !ptr_in_range) err_q <= 1'b1;
    end
  end

  imem_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_storage (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (fetch_go),
    .raddr_i (fetch_addr[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  assign instruction = nop_sel_q ? NOP_WORD : mem_rdata;
  assign instr_valid = valid_q;
  assign load_done   = done_q;
  assign load_error  = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instruction_ram.sv
// Randomized bench for instruction_ram against an array-based memory model.
module tb_instruction_ram;
  import proc_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              busy;
  logic              load_start = 1'b0;
  logic [ADDR_W-1:0] load_base = '0;
  logic [ADDR_W:0]   load_count = '0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_ready;
  logic              load_done;
  logic              load_error;
  state_t            state_dbg;

  instruction_ram #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH), .NOP_WORD (16'h0000)
  ) dut (
    .clk (clk), .reset (reset),
    .fetch_req (fetch_req), .fetch_addr (fetch_addr),
    .instruction (instruction), .instr_valid (instr_valid), .busy (busy),
    .load_start (load_start), .load_base (load_base), .load_count (load_count),
    .load_valid (load_valid), .load_data (load_data), .load_ready (load_ready),
    .load_done (load_done), .load_error (load_error), .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] last_instr;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int addr);
    return (addr < DEPTH) ? model_mem[addr] : 16'h0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    int n;
    logic saw_done, saw_valid;
    reset = 1'b1;
    load_valid = 1'b0;
    #3;
    check("rst_busy", busy, 1);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instruction, 16'h0000);
    check("rst_ready", load_ready, 0);
    check("rst_done", load_done, 0);
    check("rst_error", load_error, 0);
    check("rst_state", state_dbg, CLEAR);
    step();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    // Fetch and load requests held during the wipe must be ignored.
    fetch_req = 1'b1;
    fetch_addr = 16'd3;
    load_start = 1'b1;
    load_count = 17'd1;
    n = 0;
    saw_done = 1'b0;
    saw_valid = 1'b0;
    while (busy && n < 2000) begin
      step();
      n++;
      if (load_done) saw_done = 1'b1;
      if (instr_valid) saw_valid = 1'b1;
    end
    fetch_req = 1'b0;
    load_start = 1'b0;
    check("clear_cycles", n, DEPTH);
    check("clear_no_done", saw_done, 0);
    check("clear_no_valid", saw_valid, 0);
    check("clear_ready", load_ready, 0);
  endtask

  task automatic fetch_burst(input int n, input int max_addr);
    int a;
    fetch_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(0, max_addr);
      fetch_addr = ADDR_W'(a);
      exp_q.push_back(model_read(a));
      step();
      check("fetch_valid", instr_valid, 1);
      last_instr = exp_q.pop_front();
      check($sformatf("fetch_data@%0d", a), instruction, last_instr);
    end
    fetch_req = 1'b0;
    step();
    check("idle_valid", instr_valid, 0);
    check("idle_hold", instruction, last_instr);
  endtask

  task automatic fetch_one(input int a);
    fetch_req = 1'b1;
    fetch_addr = ADDR_W'(a);
    exp_q.push_back(model_read(a));
    step();
    fetch_req = 1'b0;
    check("fetch1_valid", instr_valid, 1);
    last_instr = exp_q.pop_front();
    check($sformatf("fetch1_data@%0d", a), instruction, last_instr);
  endtask

  task automatic do_load(input int base, input int count, input int gap_max,
                         input logic [DATA_W-1:0] data_q[$]);
    logic model_err;
    logic [DATA_W-1:0] d;
    load_base = ADDR_W'(base);
    load_count = (ADDR_W+1)'(count);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    model_err = 1'b0;
    check("start_err_clr", load_error, 0);
    if (count == 0) begin
      check("zero_done", load_done, 1);
      check("zero_busy", busy, 0);
      step();
      check("zero_done_end", load_done, 0);
      return;
    end
    check("start_ready", load_ready, 1);
    check("start_busy", busy, 1);
    check("start_done", load_done, 0);
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        load_valid = 1'b0;
        fetch_req = 1'($urandom_range(0, 1));
        fetch_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        step();
        check("gap_done", load_done, 0);
        check("gap_valid", instr_valid, 0);
        check("gap_ready", load_ready, 1);
      end
      fetch_req = 1'b0;
      d = (i < data_q.size()) ? data_q[i] : DATA_W'($urandom);
      load_valid = 1'b1;
      load_data = d;
      if (base + i < DEPTH) model_mem[base + i] = d;
      else model_err = 1'b1;
      step();
      load_valid = 1'b0;
      if (i < count - 1) begin
        check("beat_done", load_done, 0);
        check("beat_ready", load_ready, 1);
      end
    end
    check("end_done", load_done, 1);
    check("end_ready", load_ready, 0);
    check("end_busy", busy, 0);
    check("end_error", load_error, model_err);
    step();
    check("end_done_pulse", load_done, 0);
    check("end_error_hold", load_error, model_err);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DATA_W-1:0] none_q[$];
    logic [DATA_W-1:0] prog_q[$];
    logic saw_done;

    apply_reset();
    fetch_one(5);

    prog_q = '{16'hA001, 16'hA404};
    do_load(0, 2, 0, prog_q);
    fetch_one(0);
    fetch_one(1);
    fetch_one(2);

    do_load(20, 3, 2, none_q);
    fetch_burst(4, 24);

    // Overflowing session: two beats land, two are discarded.
    do_load(254, 4, 1, none_q);
    fetch_one(254);
    fetch_one(255);
    fetch_one(0);
    check("err_sticky", load_error, 1);

    // load_start wins over a same-cycle fetch; zero-count session.
    fetch_req = 1'b1;
    fetch_addr = 16'd0;
    load_start = 1'b1;
    load_count = '0;
    step();
    fetch_req = 1'b0;
    load_start = 1'b0;
    check("prio_valid", instr_valid, 0);
    check("prio_done", load_done, 1);
    check("prio_busy", busy, 0);
    check("prio_err_clr", load_error, 0);
    step();
    check("prio_done_end", load_done, 0);

    fetch_one(300);

    for (int s = 0; s < 6; s++) begin
      do_load($urandom_range(0, 270), $urandom_range(1, 8), 3, none_q);
      fetch_burst(10, 400);
    end

    // Reset in the middle of a session.
    load_base = 16'd10;
    load_count = 17'd3;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 16'hBEEF;
    step();
    load_valid = 1'b0;
    check("mid_state", state_dbg, LOAD);
    saw_done = load_done;
    apply_reset();
    check("mid_no_done", saw_done, 0);
    fetch_one(10);
    fetch_burst(8, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule

// File: doc/instruction_ram.md
Name: instruction_ram

Overview:
- Parametrised, writable successor to the combinational instruction ROM of the 16-bit processor.
- Holds the program in a DEPTH-word RAM and serves fetches with a registered one-cycle-latency read plus a valid strobe.
- Accepts program images over a streaming valid/ready load port, so programs change without resynthesis.
- Clears itself to NOP after reset; sits between the PC/fetch stage and a program loader (UART/bench).

Parameters:
DATA_W, 16, instruction width in bits
ADDR_W, 16, fetch/load address width
DEPTH, 256, number of instruction words; must be <= 2**ADDR_W
NOP_WORD, 16'h0000, value returned for cleared or out-of-range locations (opcode 000)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fetch_req  input  1  fetch request, sampled in IDLE only
fetch_addr  input  ADDR_W  word address to fetch
instruction  output  DATA_W  registered fetched word
instr_valid  output  1  one-cycle strobe: instruction holds the requested word
busy  output  1  high in CLEAR or LOAD; CPU must stall
load_start  input  1  begin load session (IDLE only)
load_base  input  ADDR_W  first write address, latched on load_start
load_count  input  ADDR_W+1  number of words in the session, latched on load_start
load_valid  input  1  load_data is valid
load_data  input  DATA_W  program word
load_ready  output  1  block accepts a beat (high in LOAD)
load_done  output  1  one-cycle pulse at session end
load_error  output  1  sticky: a beat fell outside DEPTH; cleared on next accepted load_start

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=CLEAR, clr_ptr=0, instruction=NOP_WORD, instr_valid=0, load_ready=0, load_done=0, load_error=0, busy=1.
- CLEAR: each cycle writes NOP_WORD to mem[clr_ptr] and increments clr_ptr. After writing DEPTH-1, go to IDLE. busy is high for exactly DEPTH cycles after reset deassertion. Fetch and load requests are ignored.
- IDLE, fetch: on fetch_req=1 the next cycle drives instruction=mem[fetch_addr] and instr_valid=1.
  - If fetch_addr >= DEPTH, drive instruction=NOP_WORD with instr_valid=1.
  - With no request, instr_valid=0 and instruction holds its last value.
  - Back-to-back requests give one result per cycle.
- IDLE, load_start=1: latch ptr=load_base and rem=load_count, and clear load_error.
  - load_start has priority over a simultaneous fetch_req; that fetch is dropped and instr_valid=0 next cycle.
  - If load_count=0: stay in IDLE and pulse load_done next cycle.
  - Otherwise go to LOAD.
- LOAD:
  - load_ready=1. On load_valid and load_ready, write mem[ptr]=load_data (if ptr < DEPTH), then ptr++ and rem--.
  - A beat with ptr >= DEPTH is accepted and discarded, and sets load_error. Addresses do not wrap.
  - The cycle after the beat that makes rem=0: state=IDLE, load_ready=0, load_done=1 for one cycle.
  - Gaps in load_valid simply stall the session; there is no timeout.
- Ignored in LOAD/CLEAR: fetch_req (instr_valid stays 0) and load_start.
- Read-after-write: a fetch issued in the cycle after load_done returns the newly written data.
- Reset mid-operation: any state returns to CLEAR, memory is wiped, and the session is lost with no load_done.
- Width rules: ptr and rem are ADDR_W+1 bits so the overflow compare is exact. load_data is written unmodified.

Decomposition:
- Shared package (proc_pkg):
  - NOP_WORD
  - 3-bit opcode constants: ADD=000, SUB=001, HALT=011, OUT=100, LDI=101, BNE=110, JMP=111
  - state enum {CLEAR, IDLE, LOAD}
- One sub-module, imem_storage: DEPTH x DATA_W array with one write port and one synchronous read port. The FSM, pointers and handshake live in instruction_ram.

Test Plan:
- Reset release -> busy=1 for 256 cycles then 0; fetch_req with addr 5 -> next cycle instruction=16'h0000, instr_valid=1.
- load_start base=0 count=2, beats 16'hA001, 16'hA404 -> load_done pulses once; fetch 0 -> 16'hA001, fetch 1 -> 16'hA404, fetch 2 -> 16'h0000.
- count=3 with load_valid toggling 1,0,0,1,0,1 -> exactly 3 writes, load_done one cycle after the 3rd beat, load_ready low afterwards.
- base=254 count=4 -> mem[254], mem[255] written, 2 beats discarded, load_error=1 until next load_start; mem[0] unchanged.
- fetch_req with load_start in the same IDLE cycle -> no instr_valid; fetch_addr=300 in IDLE -> 16'h0000 with instr_valid=1; load_count=0 -> load_done next cycle, busy stays 0.
- reset asserted mid-LOAD after 1 of 3 beats -> no load_done, 256-cycle CLEAR, and the previously written address reads 16'h0000.
